// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Enables and flushes are decoded each cycle; forward selects, counters and the memory-freeze FSM are registered.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1,
   parameter int MEM_LAT    = 0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] ex_wreg,
   input  logic [REG_ADDR_W-1:0] mem_wreg,
   input  logic [REG_ADDR_W-1:0] wb_wreg,
   input  logic                  ex_regwrite,
   input  logic                  mem_regwrite,
   input  logic                  wb_regwrite,
   input  logic                  ex_memread,
   input  logic                  mem_access,
   input  logic                  ex_branch_taken,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  mem_wb_bubble,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_RELEASE
   } mem_state_t;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);
   localparam logic [1:0] SEL_REG  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b10;
   localparam logic [1:0] SEL_WB   = 2'b01;

   mem_state_t       mem_state_q, mem_state_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic ex_hit_rs, ex_hit_rt;
   logic mem_hit_rs, mem_hit_rt;
   logic wb_hit_rs, wb_hit_rt;
   logic stall_req;

   // Register 0 is hard-wired, so it can never be a real producer.
   function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                    input logic                  use_src,
                                    input logic [REG_ADDR_W-1:0] dst,
                                    input logic                  regwrite);
      return use_src && regwrite && (dst != '0) && (dst == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
      logic [1:0] sel;
      sel = SEL_REG;
      if (FWD_EN != 0) begin
         if (ex_hit) begin
            sel = SEL_MEM;
         end else if (mem_hit) begin
            sel = SEL_WB;
         end
      end
      return sel;
   endfunction

   always_comb begin
      ex_hit_rs  = src_hit(id_rs, id_use_rs, ex_wreg,  ex_regwrite);
      ex_hit_rt  = src_hit(id_rt, id_use_rt, ex_wreg,  ex_regwrite);
      mem_hit_rs = src_hit(id_rs, id_use_rs, mem_wreg, mem_regwrite);
      mem_hit_rt = src_hit(id_rt, id_use_rt, mem_wreg, mem_regwrite);
      wb_hit_rs  = src_hit(id_rs, id_use_rs, wb_wreg,  wb_regwrite);
      wb_hit_rt  = src_hit(id_rt, id_use_rt, wb_wreg,  wb_regwrite);
      if (FWD_EN != 0) begin
         stall_req = ex_memread && (ex_hit_rs || ex_hit_rt);
      end else begin
         stall_req = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt || wb_hit_rs || wb_hit_rt;
      end
   end

   // Priority: memory freeze, then taken-branch flush (stalled instruction is wrong-path), then stall.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      if (mem_state_q == MEM_WAIT) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (stall_req) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (id_ex_flush) begin
         fwd_a_d = SEL_REG;
         fwd_b_d = SEL_REG;
      end else if (id_ex_write) begin
         fwd_a_d = fwd_sel(ex_hit_rs, mem_hit_rs);
         fwd_b_d = fwd_sel(ex_hit_rt, mem_hit_rt);
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (if_id_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end

      mem_state_d = mem_state_q;
      lat_cnt_d   = lat_cnt_q;
      case (mem_state_q)
         MEM_IDLE: begin
            if (mem_access && (LAT_LOAD != 4'd0)) begin
               mem_state_d = MEM_WAIT;
               lat_cnt_d   = LAT_LOAD;
            end
         end
         MEM_WAIT: begin
            if (lat_cnt_q <= 4'd1) begin
               mem_state_d = MEM_RELEASE;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         MEM_RELEASE: mem_state_d = MEM_IDLE;
         default:     mem_state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_state_q <= MEM_IDLE;
         lat_cnt_q   <= '0;
         fwd_a_q     <= SEL_REG;
         fwd_b_q     <= SEL_REG;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         mem_state_q <= mem_state_d;
         lat_cnt_q   <= lat_cnt_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: four controller configurations share one input stream and are
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
   logic       id_use_rs, id_use_rt;
   logic       ex_regwrite, mem_regwrite, wb_regwrite;
   logic       ex_memread, mem_access, ex_branch_taken;

   logic [10:0] ctrl_obs  [N];
   logic [15:0] stall_obs [N];
   logic [15:0] flush_obs [N];

   int vectors     = 0;
   int miscompares = 0;

   int       m_freeze  [N];
   bit       m_release [N];
   bit [1:0] m_fwd_a   [N];
   bit [1:0] m_fwd_b   [N];
   int       m_stall   [N];
   int       m_flush   [N];

   always #5 clock = ~clock;

   // Instance 0: forwarding, 1: forwarding + 3-cycle memory, 2: stall-only, 3: stall-only + memory + 4-bit counters.
   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int W = (g == 3) ? 4 : 16;
      logic         pc_write, if_id_write, id_ex_write, ex_mem_write;
      logic         if_id_flush, id_ex_flush, mem_wb_bubble;
      logic [1:0]   fwd_a, fwd_b;
      logic [W-1:0] stall_cnt, flush_cnt;

      pipe_hazard_ctrl #(
         .REG_ADDR_W(5),
         .FWD_EN    ((g < 2) ? 1 : 0),
         .MEM_LAT   ((g % 2 == 1) ? 3 : 0),
         .CNT_W     (W)
      ) u_dut (
         .clk            (clock),
         .reset          (reset),
         .id_rs          (id_rs),
         .id_rt          (id_rt),
         .id_use_rs      (id_use_rs),
         .id_use_rt      (id_use_rt),
         .ex_wreg        (ex_wreg),
         .mem_wreg       (mem_wreg),
         .wb_wreg        (wb_wreg),
         .ex_regwrite    (ex_regwrite),
         .mem_regwrite   (mem_regwrite),
         .wb_regwrite    (wb_regwrite),
         .ex_memread     (ex_memread),
         .mem_access     (mem_access),
         .ex_branch_taken(ex_branch_taken),
         .pc_write       (pc_write),
         .if_id_write    (if_id_write),
         .id_ex_write    (id_ex_write),
         .ex_mem_write   (ex_mem_write),
         .if_id_flush    (if_id_flush),
         .id_ex_flush    (id_ex_flush),
         .mem_wb_bubble  (mem_wb_bubble),
         .fwd_a          (fwd_a),
         .fwd_b          (fwd_b),
         .stall_cnt      (stall_cnt),
         .flush_cnt      (flush_cnt)
      );

      assign ctrl_obs[g]  = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                             if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b};
      assign stall_obs[g] = 16'(stall_cnt);
      assign flush_obs[g] = 16'(flush_cnt);
   end

   function automatic bit cfgFwd(int i);
      return i < 2;
   endfunction

   function automatic int cfgLat(int i);
      return (i % 2 == 1) ? 3 : 0;
   endfunction

   function automatic int cfgMax(int i);
      return (i == 3) ? 15 : 65535;
   endfunction

   function automatic bit reads(logic [4:0] src, logic use_src, logic [4:0] dst, logic rw);
      return use_src && rw && (dst != 5'd0) && (dst == src);
   endfunction

   // Which later stage currently holds the newest value of an ID source operand.
   function automatic bit [1:0] operandSource(int i, logic [4:0] src, logic use_src);
      if (!cfgFwd(i)) return 2'b00;
      if (reads(src, use_src, ex_wreg, ex_regwrite)) return 2'b10;
      if (reads(src, use_src, mem_wreg, mem_regwrite)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic checkOutput();
      bit       frozen, hazard, pc, fl;
      bit [1:0] sa, sb;
      bit [6:0] ctl;
      logic [10:0] exp_ctrl;
      for (int i = 0; i < N; i++) begin
         frozen = (m_freeze[i] > 0);
         if (cfgFwd(i)) begin
            hazard = ex_memread && (reads(id_rs, id_use_rs, ex_wreg, ex_regwrite) ||
                                    reads(id_rt, id_use_rt, ex_wreg, ex_regwrite));
         end else begin
            hazard = 1'b0;
            foreach (ctrl_obs[k]) begin
               if (k == 0) begin
                  hazard = reads(id_rs, id_use_rs, ex_wreg,  ex_regwrite)  || reads(id_rt, id_use_rt, ex_wreg,  ex_regwrite)  ||
                           reads(id_rs, id_use_rs, mem_wreg, mem_regwrite) || reads(id_rt, id_use_rt, mem_wreg, mem_regwrite) ||
                           reads(id_rs, id_use_rs, wb_wreg,  wb_regwrite)  || reads(id_rt, id_use_rt, wb_wreg,  wb_regwrite);
               end
            end
         end
         if (frozen)               ctl = 7'b0000_001;
         else if (ex_branch_taken) ctl = 7'b1111_110;
         else if (hazard)          ctl = 7'b0011_010;
         else                      ctl = 7'b1111_000;
         exp_ctrl = {ctl, m_fwd_a[i], m_fwd_b[i]};

         vectors++;
         assert (ctrl_obs[i] === exp_ctrl) else begin
            miscompares++;
            $error("[TB] FAIL ctrl[%0d] observed=%b expected=%b", i, ctrl_obs[i], exp_ctrl);
         end
         vectors++;
         assert (stall_obs[i] === 16'(m_stall[i])) else begin
            miscompares++;
            $error("[TB] FAIL stall_cnt[%0d] observed=%0d expected=%0d", i, stall_obs[i], m_stall[i]);
         end
         vectors++;
         assert (flush_obs[i] === 16'(m_flush[i])) else begin
            miscompares++;
            $error("[TB] FAIL flush_cnt[%0d] observed=%0d expected=%0d", i, flush_obs[i], m_flush[i]);
         end

         pc = ctl[6];
         fl = ctl[2];
         sa = operandSource(i, id_rs, id_use_rs);
         sb = operandSource(i, id_rt, id_use_rt);
         if (reset) begin
            m_freeze[i] = 0; m_release[i] = 0; m_fwd_a[i] = 0; m_fwd_b[i] = 0;
            m_stall[i] = 0;  m_flush[i] = 0;
         end else begin
            if (!pc && m_stall[i] < cfgMax(i)) m_stall[i]++;
            if (fl && m_flush[i] < cfgMax(i)) m_flush[i]++;
            if (ctl[1]) begin
               m_fwd_a[i] = 0; m_fwd_b[i] = 0;
            end else if (ctl[4]) begin
               m_fwd_a[i] = sa; m_fwd_b[i] = sb;
            end
            if (m_freeze[i] > 0) begin
               m_freeze[i]--;
               if (m_freeze[i] == 0) m_release[i] = 1;
            end else if (m_release[i]) begin
               m_release[i] = 0;
            end else if (cfgLat(i) > 0 && mem_access) begin
               m_freeze[i] = cfgLat(i);
            end
         end
      end
   endtask

   task automatic expectEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      #1;
      checkOutput();
      @(negedge clock);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] exw, input logic exrw, input logic exmr,
                        input logic [4:0] memw, input logic memrw,
                        input logic [4:0] wbw, input logic wbrw,
                        input logic macc, input logic br);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_wreg = exw; ex_regwrite = exrw; ex_memread = exmr;
      mem_wreg = memw; mem_regwrite = memrw;
      wb_wreg = wbw; wb_regwrite = wbrw;
      mem_access = macc; ex_branch_taken = br;
   endtask

   task automatic resetPulse();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         m_freeze[i] = 0; m_release[i] = 0; m_fwd_a[i] = 0; m_fwd_b[i] = 0;
         m_stall[i] = 0;  m_flush[i] = 0;
      end
      @(negedge clock);
      @(negedge clock);
      #1;
      resetPulse();
      expectEq("reset_ctrl", 16'(ctrl_obs[0]), 16'b111_1000_0000);

      // lw $8 in EXE, add $9,$8,$8 in ID; then the load moves to MEM.
      resetPulse();
      drive(8, 8, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      expectEq("loaduse_pc_write", 16'(ctrl_obs[0][10]), 16'd0);
      expectEq("loaduse_id_ex_flush", 16'(ctrl_obs[0][5]), 16'd1);
      applyStimulus();
      drive(8, 8, 1, 1, 0, 0, 0, 8, 1, 0, 0, 1, 0);
      applyStimulus();
      expectEq("loaduse_fwd", 16'(ctrl_obs[0][3:0]), 16'b0101);
      expectEq("loaduse_stall_cnt", stall_obs[0], 16'd1);

      // addi $17 in EXE feeding sub $9,$17,$16; then the same with $0 as destination.
      resetPulse();
      drive(17, 16, 1, 1, 17, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus();
      expectEq("exfwd_fwd", 16'(ctrl_obs[0][3:0]), 16'b1000);
      expectEq("exfwd_no_stall", stall_obs[0], 16'd0);
      drive(0, 16, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus();
      expectEq("exfwd_r0_fwd", 16'(ctrl_obs[0][3:0]), 16'b0000);

      resetPulse();
      drive(8, 8, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 1);
      #1;
      expectEq("branch_ctrl", 16'(ctrl_obs[0][10:4]), 16'b1111_110);
      applyStimulus();
      expectEq("branch_flush_cnt", flush_obs[0], 16'd1);
      expectEq("branch_stall_cnt", stall_obs[0], 16'd0);

      // Single store in MEM on the 3-cycle-latency instance.
      resetPulse();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus();
      mem_access = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         expectEq("freeze_ctrl", 16'(ctrl_obs[1][10:4]), 16'b0000_001);
         applyStimulus();
      end
      #1;
      expectEq("release_ctrl", 16'(ctrl_obs[1][10:4]), 16'b1111_000);
      applyStimulus();
      expectEq("freeze_stall_cnt", stall_obs[1], 16'd3);

      resetPulse();
      mem_access = 1'b1;
      for (int c = 0; c < 9; c++) applyStimulus();
      mem_access = 1'b0;
      for (int c = 0; c < 2; c++) applyStimulus();
      expectEq("b2b_stall_cnt", stall_obs[1], 16'd6);

      // Reset lands in the second freeze cycle.
      resetPulse();
      mem_access = 1'b1;
      applyStimulus();
      mem_access = 1'b0;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      #1;
      expectEq("midreset_ctrl", 16'(ctrl_obs[1][10:4]), 16'b1111_000);
      expectEq("midreset_stall_cnt", stall_obs[1], 16'd0);

      // Stall-only instance: addi $17 then srl $19,$17,1 walks the producer through EXE, MEM, WB.
      resetPulse();
      drive(17, 0, 1, 0, 17, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus();
      drive(17, 0, 1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
      applyStimulus();
      drive(17, 0, 1, 0, 0, 0, 0, 0, 0, 17, 1, 0, 0);
      applyStimulus();
      drive(17, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      expectEq("raw_release_pc_write", 16'(ctrl_obs[2][10]), 16'd1);
      applyStimulus();
      expectEq("raw_stall_cnt", stall_obs[2], 16'd3);
      expectEq("raw_fwd_a", 16'(ctrl_obs[2][3:2]), 16'b00);

      resetPulse();
      drive(5, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
      for (int c = 0; c < 20; c++) applyStimulus();
      expectEq("sat_stall_cnt", stall_obs[3], 16'd15);
      expectEq("nosat_stall_cnt", stall_obs[2], 16'd20);

      // Random traffic over a small register window so hazards are frequent.
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 39) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
         applyStimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Replaces the constant write-enable and flush tie-offs on the four pipeline registers and PC.
- Adds three capabilities: load-use stalls, EX/MEM-to-EX forwarding with registered select codes, and taken-branch flush.
- Also freezes the whole pipeline for a configurable data-memory latency, and keeps saturating stall and flush counters.

Parameters:
- REG_ADDR_W, 5: register specifier width.
- FWD_EN, 1: 1 = resolve RAW hazards by forwarding; 0 = stall until the producer has left WB.
- MEM_LAT, 0: extra freeze cycles per data-memory access (0 to 15); 0 = single-cycle memory.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt.
- ex_wreg, mem_wreg, wb_wreg  in  REG_ADDR_W  destination register in EXE / MEM / WB.
- ex_regwrite, mem_regwrite, wb_regwrite  in  1  stage writes a register.
- ex_memread  in  1  instruction in EXE is a load.
- mem_access  in  1  instruction in MEM reads or writes data memory.
- ex_branch_taken  in  1  branch resolved taken in EXE (branch & zero).
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  register enables.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1  insert a NOP on the next edge.
- fwd_a, fwd_b  out  2  registered EXE operand selects: 00 = register file, 10 = aluResult_M, 01 = writeData (WB).
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

Behaviour:
- Reset (synchronous): all enables 1; all flushes and bubble 0; fwd_a and fwd_b 00; counters 0; memory FSM in IDLE.
- Register 0: never creates a hazard and is never forwarded. A match requires the register to be nonzero, the stage regwrite to be 1, and the corresponding id_use_* to be 1.
- Load-use hazard (FWD_EN=1): ex_memread and ex_wreg matches an ID source.
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1, for exactly one cycle.
  - The consumer then sees the load in MEM and forwards 01 on advance.
- RAW stall (FWD_EN=0): any EXE, MEM or WB destination matching an ID source stalls as in the load-use case.
  - This takes up to 3 cycles. The register file is write-on-edge, so no same-cycle bypass exists.
- Forwarding selects: computed combinationally from ID and latched into fwd_a / fwd_b on the edge where id_ex_write=1.
  - EXE producer gives 10; MEM producer gives 01; EXE takes priority.
  - Cleared to 00 on the same edge when id_ex_flush=1.
  - Held when id_ex_write=0.
  - With FWD_EN=0, always 00.
- Branch flush: ex_branch_taken gives if_id_flush=1 and id_ex_flush=1 for one cycle, with pc_write=1.
  - Overrides a simultaneous load-use or RAW stall, because the stalled instruction is wrong-path.
  - flush_cnt increments by 1 per flush cycle.
- Memory freeze FSM (only active when MEM_LAT>0):
  - IDLE: on mem_access, go to WAIT and load the counter with MEM_LAT.
  - WAIT:
    - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, mem_wb_bubble=1.
    - Decrement the counter; when it reaches 1, go to RELEASE.
  - RELEASE:
    - Outputs: normal hazard logic; mem_wb_bubble=0.
    - Go to IDLE. A new mem_access is not re-detected in this cycle.
  - Back-to-back accesses therefore each incur MEM_LAT freeze cycles.
  - Freeze overrides branch flush and load-use. A taken branch held in EXE applies its flush in the RELEASE cycle.
  - fwd_a / fwd_b are held throughout the freeze.
- stall_cnt: increments on every cycle where pc_write=0. Both counters saturate at all-ones.
- Reset mid-freeze: FSM returns to IDLE on the same edge; no residual freeze.

Test Plan:
- Load-use: `lw $8,0($0)` then `add $9,$8,$8` (FWD_EN=1).
  - Expect one cycle with pc_write=0 and id_ex_flush=1.
  - Then fwd_a=fwd_b=01 when the add enters EXE; stall_cnt=1.
- EXE forward: `addi $17,$0,5` then `sub $9,$17,$16` → fwd_a=10, fwd_b=00, no stall.
  - Same sequence with $0 as the destination → fwd_a=00.
- Branch vs stall: ex_branch_taken=1 in the same cycle as a load-use match.
  - Expect if_id_flush=id_ex_flush=1 and pc_write=1; flush_cnt=1; stall_cnt unchanged.
- Memory freeze with MEM_LAT=3: a sw in MEM.
  - Expect exactly 3 cycles of all enables 0 with mem_wb_bubble=1, then one RELEASE cycle; stall_cnt=3.
  - Two consecutive sw → 6 freeze cycles total.
- FWD_EN=0: `addi $17,...` then `srl $19,$17,1` → 3 stall cycles, fwd_a stays 00.
- Reset: assert reset in the second WAIT cycle → next cycle all enables 1, counters 0, FSM in IDLE.
- Saturation (CNT_W=4): 20 stall cycles → stall_cnt=15.
